// File: rtl/inst_mem_loader.sv
// inst_mem_loader
//   Writer side of the byte-programmable instruction memory. Bytes arrive from
//   the programming front end over a valid/ready handshake. Each byte is written
//   to the next address, starting at 0, with a three-cycle
//   setup / strobe / hold sequence. After the final byte the memory is read back
//   as words, the byte sum is recomputed, and pass/fail is reported.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               begin a new load (honoured only when idle or done)
//   i_byte, i_byte_valid,
//   i_byte_last, o_byte_ready   byte stream handshake
//   o_mem_address, o_mem_data,
//   o_mem_cs              memory byte-write port (cs is the write strobe)
//   i_mem_rdata           memory read word at o_mem_address (lane 0 = lowest address)
//   o_busy, o_done, o_error     load status
//   o_byte_count, o_checksum    bytes written and their mod-256 sum
module inst_mem_loader #(
   parameter int MEM_DEPTH = 56,
   parameter int ADDR_BITS = 8,
   parameter int BYTE_BITS = 8,
   parameter int WORD_BITS = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [BYTE_BITS-1:0] i_byte,
   input  logic                 i_byte_valid,
   input  logic                 i_byte_last,
   output logic                 o_byte_ready,
   output logic [ADDR_BITS-1:0] o_mem_address,
   output logic [BYTE_BITS-1:0] o_mem_data,
   output logic                 o_mem_cs,
   input  logic [WORD_BITS-1:0] i_mem_rdata,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_error,
   output logic [ADDR_BITS-1:0] o_byte_count,
   output logic [BYTE_BITS-1:0] o_checksum
);

   localparam int LANES = WORD_BITS / BYTE_BITS;

   typedef enum logic [2:0] {
      IDLE, WAIT_BYTE, SETUP, STROBE, HOLD, VFY_ADDR, VFY_SAMPLE, DONE
   } state_t;

   state_t               state, state_nxt;
   logic [ADDR_BITS-1:0] count, vaddr;
   logic [BYTE_BITS-1:0] checksum, vsum, byte_q;
   logic                 last_q, error_q;

   logic                 full;
   logic                 vfy_last;
   logic [BYTE_BITS-1:0] word_sum;

   // Sum of the lanes of one read word that lie below the loaded byte count;
   // lanes past the end hold stale memory contents and must not contribute.
   function automatic logic [BYTE_BITS-1:0] lane_sum(
      input logic [WORD_BITS-1:0] word,
      input logic [ADDR_BITS-1:0] base,
      input logic [ADDR_BITS-1:0] limit
   );
      logic [BYTE_BITS-1:0] acc;
      acc = '0;
      for (int k = 0; k < LANES; k++) begin
         if (({1'b0, base} + (ADDR_BITS+1)'(k)) < {1'b0, limit})
            acc = acc + word[k*BYTE_BITS +: BYTE_BITS];
      end
      return acc;
   endfunction

   assign full     = (count == ADDR_BITS'(MEM_DEPTH));
   assign word_sum = vsum + lane_sum(i_mem_rdata, vaddr, count);
   assign vfy_last = ({1'b0, vaddr} + (ADDR_BITS+1)'(LANES)) >= {1'b0, count};

   // ---- state register ----
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // ---- next state and output decode ----
   always_comb begin
      state_nxt     = state;
      o_byte_ready  = 1'b0;
      o_mem_cs      = 1'b0;
      o_mem_address = '0;
      o_mem_data    = '0;
      o_busy        = 1'b1;
      o_done        = 1'b0;
      unique case (state)
         IDLE: begin
            o_busy = 1'b0;
            if (i_start) state_nxt = WAIT_BYTE;
         end
         WAIT_BYTE: begin
            o_byte_ready = 1'b1;
            if (i_byte_valid) state_nxt = full ? DONE : SETUP;
         end
         SETUP: begin
            o_mem_address = count;
            o_mem_data    = byte_q;
            state_nxt     = STROBE;
         end
         STROBE: begin
            o_mem_address = count;
            o_mem_data    = byte_q;
            o_mem_cs      = 1'b1;
            state_nxt     = HOLD;
         end
         HOLD: begin
            o_mem_address = count;
            o_mem_data    = byte_q;
            state_nxt     = last_q ? VFY_ADDR : WAIT_BYTE;
         end
         VFY_ADDR: begin
            o_mem_address = vaddr;
            state_nxt     = VFY_SAMPLE;
         end
         VFY_SAMPLE: begin
            o_mem_address = vaddr;
            state_nxt     = vfy_last ? DONE : VFY_ADDR;
         end
         DONE: begin
            o_busy = 1'b0;
            o_done = 1'b1;
            if (i_start) state_nxt = WAIT_BYTE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- load / verify datapath ----
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count    <= '0;
         checksum <= '0;
         vsum     <= '0;
         vaddr    <= '0;
         byte_q   <= '0;
         last_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (i_start) begin
                  count    <= '0;
                  checksum <= '0;
                  error_q  <= 1'b0;
               end
            end
            WAIT_BYTE: begin
               if (i_byte_valid) begin
                  // A byte offered to a full memory is dropped and flagged.
                  if (full) error_q <= 1'b1;
                  else begin
                     byte_q <= i_byte;
                     last_q <= i_byte_last;
                  end
               end
            end
            HOLD: begin
               // Count advances only after the strobe so the address holds.
               count    <= count + ADDR_BITS'(1);
               checksum <= checksum + byte_q;
               if (last_q) begin
                  vaddr <= '0;
                  vsum  <= '0;
               end
            end
            VFY_SAMPLE: begin
               vsum  <= word_sum;
               vaddr <= vaddr + ADDR_BITS'(LANES);
               if (vfy_last) error_q <= (word_sum != checksum);
            end
            default: ;
         endcase
      end
   end

   assign o_error      = error_q;
   assign o_byte_count = count;
   assign o_checksum   = checksum;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

   localparam int MEM_DEPTH = 56;
   localparam int ADDR_BITS = 8;
   localparam int BYTE_BITS = 8;
   localparam int WORD_BITS = 32;

   logic                 i_clk = 1'b0;
   logic                 i_rst, i_start, i_byte_valid, i_byte_last;
   logic [BYTE_BITS-1:0] i_byte;
   logic                 o_byte_ready, o_mem_cs, o_busy, o_done, o_error;
   logic [ADDR_BITS-1:0] o_mem_address, o_byte_count;
   logic [BYTE_BITS-1:0] o_mem_data, o_checksum;
   logic [WORD_BITS-1:0] i_mem_rdata;

   inst_mem_loader #(
      .MEM_DEPTH(MEM_DEPTH), .ADDR_BITS(ADDR_BITS),
      .BYTE_BITS(BYTE_BITS), .WORD_BITS(WORD_BITS)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
      .i_byte(i_byte), .i_byte_valid(i_byte_valid), .i_byte_last(i_byte_last),
      .o_byte_ready(o_byte_ready), .o_mem_address(o_mem_address),
      .o_mem_data(o_mem_data), .o_mem_cs(o_mem_cs), .i_mem_rdata(i_mem_rdata),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
      .o_byte_count(o_byte_count), .o_checksum(o_checksum)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      logic       err;
      logic [7:0] cnt;
      logic [7:0] csum;
      int         lat;
   } res_t;

   wr_t  wr_q[$];
   res_t res_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   time  t_acc = 0;
   int   corrupt_addr = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Model memory: byte writes on the strobe, combinational word read.
   logic [7:0] mem [0:MEM_DEPTH-1];

   always @(posedge i_clk) begin
      if (o_mem_cs && int'(o_mem_address) < MEM_DEPTH)
         mem[o_mem_address] <= (int'(o_mem_address) == corrupt_addr) ? 8'h00 : o_mem_data;
   end

   always_comb begin
      i_mem_rdata = '0;
      for (int k = 0; k < 4; k++)
         if (int'(o_mem_address) + k < MEM_DEPTH)
            i_mem_rdata[k*8 +: 8] = mem[int'(o_mem_address) + k];
   end

   // Write monitor: pops expected writes on each strobe and checks that
   // address/data are stable the cycle before and after it.
   logic       p_cs = 1'b0;
   logic [7:0] p_addr = '0;
   logic [7:0] p_data = '0;

   always @(negedge i_clk) begin
      if (!i_rst && p_cs) begin
         check("cs_width", {31'd0, o_mem_cs}, 32'd0);
         check("post_addr", {24'd0, o_mem_address}, {24'd0, p_addr});
         check("post_data", {24'd0, o_mem_data}, {24'd0, p_data});
      end
      if (o_mem_cs) begin
         check("pre_addr", {24'd0, o_mem_address}, {24'd0, p_addr});
         check("pre_data", {24'd0, o_mem_data}, {24'd0, p_data});
         if (wr_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", o_mem_address, o_mem_data);
         end else begin : pop_wr
            wr_t e;
            e = wr_q.pop_front();
            check("wr_addr", {24'd0, o_mem_address}, {24'd0, e.addr});
            check("wr_data", {24'd0, o_mem_data}, {24'd0, e.data});
         end
      end
      p_cs   <= o_mem_cs;
      p_addr <= o_mem_address;
      p_data <= o_mem_data;
   end

   // Completion monitor: pops the expected result when o_done rises.
   logic p_done = 1'b0;

   always @(negedge i_clk) begin
      if (o_done && !p_done) begin
         if (res_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done, expected none");
         end else begin : pop_res
            res_t e;
            e = res_q.pop_front();
            check("done_error", {31'd0, o_error}, {31'd0, e.err});
            check("done_count", {24'd0, o_byte_count}, {24'd0, e.cnt});
            check("done_csum", {24'd0, o_checksum}, {24'd0, e.csum});
            if (e.lat >= 0)
               check("done_latency", 32'(($time - t_acc - 5) / 10), 32'(e.lat));
         end
      end
      p_done <= o_done;
   end

   task automatic do_start();
      @(negedge i_clk);
      i_start = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
      int guard;
      guard = 0;
      repeat (gap) @(negedge i_clk);
      @(negedge i_clk);
      i_byte       = b;
      i_byte_last  = last;
      i_byte_valid = 1'b1;
      while (!o_byte_ready && guard < 100) begin
         @(negedge i_clk);
         guard++;
      end
      if (!o_byte_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: got ready=0, expected ready=1 within 100 cycles");
      end else begin
         @(posedge i_clk);
         t_acc = $time;
      end
      #1;
      i_byte_valid = 1'b0;
      i_byte_last  = 1'b0;
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      while (!o_done && guard < 300) begin
         @(negedge i_clk);
         guard++;
      end
      if (!o_done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got done=0, expected done=1 within 300 cycles");
      end
   endtask

   task automatic load(input int n, input logic [7:0] base, input logic [7:0] step,
                       input int gap, input logic exp_err, input logic [7:0] exp_csum,
                       input int exp_lat);
      logic [7:0] b;
      do_start();
      res_q.push_back('{exp_err, 8'(n), exp_csum, exp_lat});
      b = base;
      for (int i = 0; i < n; i++) begin
         wr_q.push_back('{8'(i), b});
         send_byte(b, (i == n - 1), gap);
         b = b + step;
      end
      wait_done();
   endtask

   initial begin
      int guard;
      i_rst        = 1'b1;
      i_start      = 1'b1;
      i_byte_valid = 1'b0;
      i_byte_last  = 1'b0;
      i_byte       = '0;

      // Reset, with a start pulse held high that must be ignored.
      @(posedge i_clk);
      @(posedge i_clk);
      @(negedge i_clk);
      check("rst_ctrl", {27'd0, o_byte_ready, o_mem_cs, o_busy, o_done, o_error}, 32'd0);
      check("rst_addr", {24'd0, o_mem_address}, 32'd0);
      check("rst_data", {24'd0, o_mem_data}, 32'd0);
      check("rst_count", {24'd0, o_byte_count}, 32'd0);
      check("rst_csum", {24'd0, o_checksum}, 32'd0);
      i_rst   = 1'b0;
      i_start = 1'b0;
      @(negedge i_clk);
      check("idle_after_rst", {31'd0, o_busy}, 32'd0);

      // Single byte.
      load(1, 8'hA5, 8'h00, 0, 1'b0, 8'hA5, 5);

      // Eight bytes 0x01..0x08 with gaps; a start pulse mid-load is ignored.
      do_start();
      res_q.push_back('{1'b0, 8'd8, 8'h24, 7});
      for (int i = 0; i < 8; i++) begin
         wr_q.push_back('{8'(i), 8'(i + 1)});
         send_byte(8'(i + 1), (i == 7), 1);
         if (i == 2) begin
            guard = 0;
            while (!o_byte_ready && guard < 20) begin
               @(negedge i_clk);
               guard++;
            end
            i_start = 1'b1;
            @(posedge i_clk);
            #1 i_start = 1'b0;
            @(negedge i_clk);
            check("start_ignored_busy", {31'd0, o_busy}, 32'd1);
            check("start_ignored_count", {24'd0, o_byte_count}, 32'd3);
         end
      end
      wait_done();

      // Full memory, last on byte 56.
      load(56, 8'hFF, 8'h00, 0, 1'b0, 8'hC8, 31);

      // Overflow: 56 bytes without last, then a 57th byte that must not be written.
      do_start();
      res_q.push_back('{1'b1, 8'd56, 8'hC8, -1});
      for (int i = 0; i < 56; i++) begin
         wr_q.push_back('{8'(i), 8'hFF});
         send_byte(8'hFF, 1'b0, 0);
      end
      send_byte(8'hFF, 1'b0, 0);
      wait_done();
      @(negedge i_clk);
      check("ovf_busy", {31'd0, o_busy}, 32'd0);

      // Verify failure: address 4 corrupted in the model memory.
      corrupt_addr = 4;
      load(5, 8'h10, 8'h01, 0, 1'b1, 8'h5A, 7);
      corrupt_addr = -1;

      // Same load intact: stale 0xFF in lanes past the end must be ignored.
      load(5, 8'h10, 8'h01, 0, 1'b0, 8'h5A, 7);

      // Reset during the strobe of the second byte.
      do_start();
      wr_q.push_back('{8'd0, 8'h76});
      send_byte(8'h76, 1'b0, 0);
      wr_q.push_back('{8'd1, 8'h77});
      send_byte(8'h77, 1'b0, 0);
      guard = 0;
      while (!o_mem_cs && guard < 20) begin
         @(negedge i_clk);
         guard++;
      end
      check("strobe_seen", {31'd0, o_mem_cs}, 32'd1);
      check("pre_rst_count", {24'd0, o_byte_count}, 32'd1);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      check("rst_cs", {31'd0, o_mem_cs}, 32'd0);
      check("rst_mid_ctrl", {28'd0, o_byte_ready, o_busy, o_done, o_error}, 32'd0);
      check("rst_mid_addr", {24'd0, o_mem_address}, 32'd0);
      check("rst_mid_data", {24'd0, o_mem_data}, 32'd0);
      check("rst_mid_count", {24'd0, o_byte_count}, 32'd0);
      check("rst_mid_csum", {24'd0, o_checksum}, 32'd0);
      @(posedge i_clk);
      #1 i_rst = 1'b0;

      // Fresh start reloads from address 0.
      load(2, 8'h31, 8'h01, 0, 1'b0, 8'h63, 5);

      @(negedge i_clk);
      check("wr_q_empty", 32'(wr_q.size()), 32'd0);
      check("res_q_empty", 32'(res_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
